// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I-subset core sharing one req/ready memory port
// between instruction fetch and load/store.
// Optional feature macro: MC_CORE_ILLEGAL_TRAP_EN
//   defined   -> unsupported instructions halt the core (HALT state, halted=1)
//   undefined -> unsupported instructions retire as NOPs, halted tied 0
module mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] debug_pc,
    output logic [31:0] debug_instr,
    output logic        debug_retire,
    output logic        halted
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t state_q, state_n;

    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] ir_q, ir_n;
    logic [XLEN-1:0] alu_q, alu_n;
    logic [XLEN-1:0] rs2_q, rs2_n;
    logic [XLEN-1:0] ld_q, ld_n;

    logic            mem_req_q, mem_req_n;
    logic            mem_we_q, mem_we_n;
    logic [XLEN-1:0] mem_addr_q, mem_addr_n;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_n;
    logic            retire_q, retire_n;

    logic [XLEN-1:0] rf [NUM_REGS];
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    // Instruction fields and immediates
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign rd_idx  = ir_q[7 +: IDX_W];
    assign rs1_idx = ir_q[15 +: IDX_W];
    assign rs2_idx = ir_q[20 +: IDX_W];
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u   = {ir_q[31:12], 12'b0};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1_idx == '0) ? '0 : rf[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : rf[rs2_idx];

    logic is_store, is_load, is_jal;
    assign is_store = (opcode == OPC_STORE);
    assign is_load  = (opcode == OPC_LOAD);
    assign is_jal   = (opcode == OPC_JAL);

    // Legality of the current instruction against the supported subset
    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_OP_IMM: legal = (funct3 != 3'b001) && (funct3 != 3'b011) && (funct3 != 3'b101);
            OPC_OP: begin
                if (funct7 == 7'b0000000)
                    legal = (funct3 != 3'b001) && (funct3 != 3'b011) && (funct3 != 3'b101);
                else
                    legal = (funct7 == 7'b0100000) && (funct3 == 3'b000);
            end
            OPC_LUI, OPC_JAL: legal = 1'b1;
            OPC_BRANCH:       legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            OPC_LOAD, OPC_STORE: legal = (funct3 == 3'b010);
            default:          legal = 1'b0;
        endcase
    end

    // ALU: register/immediate ops, LUI pass-through and load/store address
    logic [XLEN-1:0] op_b, alu_arith, exec_res;
    logic            slt;
    always_comb begin
        op_b      = (opcode == OPC_OP) ? rs2_val : imm_i;
        slt       = ($signed(rs1_val) < $signed(op_b));
        alu_arith = rs1_val + op_b;
        case (funct3)
            3'b000:  alu_arith = ((opcode == OPC_OP) && funct7[5]) ? (rs1_val - op_b) : (rs1_val + op_b);
            3'b010:  alu_arith = {{(XLEN-1){1'b0}}, slt};
            3'b100:  alu_arith = rs1_val ^ op_b;
            3'b110:  alu_arith = rs1_val | op_b;
            3'b111:  alu_arith = rs1_val & op_b;
            default: alu_arith = rs1_val + op_b;
        endcase
        case (opcode)
            OPC_LUI:   exec_res = imm_u;
            OPC_LOAD:  exec_res = rs1_val + imm_i;
            OPC_STORE: exec_res = rs1_val + imm_s;
            default:   exec_res = alu_arith;
        endcase
    end

    logic br_taken;
    assign br_taken = (funct3 == 3'b000) ? (rs1_val == rs2_val) : (rs1_val != rs2_val);

    logic mem_done;
    assign mem_done = mem_req_q && mem_ready;

    // Next-state, datapath next values and registered-output next values
    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        ir_n        = ir_q;
        alu_n       = alu_q;
        rs2_n       = rs2_q;
        ld_n        = ld_q;
        retire_n    = 1'b0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        mem_req_n   = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;

        case (state_q)
            S_FETCH: begin
                if (mem_done) begin
                    ir_n    = mem_rdata;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_n = exec_res;
                rs2_n = rs2_val;
                if (!legal) begin
`ifdef MC_CORE_ILLEGAL_TRAP_EN
                    state_n = S_HALT;
`else
                    pc_n     = pc_q + XLEN'(4);
                    retire_n = 1'b1;
                    state_n  = S_FETCH;
`endif
                end else if (opcode == OPC_BRANCH) begin
                    pc_n     = br_taken ? (pc_q + imm_b) : (pc_q + XLEN'(4));
                    retire_n = 1'b1;
                    state_n  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    if (is_store) begin
                        pc_n     = pc_q + XLEN'(4);
                        retire_n = 1'b1;
                        state_n  = S_FETCH;
                    end else begin
                        ld_n    = mem_rdata;
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wdata = is_load ? ld_q : (is_jal ? (pc_q + XLEN'(4)) : alu_q);
                pc_n     = is_jal ? (pc_q + imm_j) : (pc_q + XLEN'(4));
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase

        // Memory port values for the cycle after this edge; stable while stalled
        if (state_n == S_FETCH) begin
            mem_req_n  = 1'b1;
            mem_addr_n = pc_n;
        end else if (state_n == S_MEM) begin
            mem_req_n   = 1'b1;
            mem_we_n    = is_store;
            mem_addr_n  = {alu_n[XLEN-1:2], 2'b00};
            mem_wdata_n = rs2_n;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_n;
    end

    // Datapath and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            alu_q       <= '0;
            rs2_q       <= '0;
            ld_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
        end else begin
            pc_q        <= pc_n;
            ir_q        <= ir_n;
            alu_q       <= alu_n;
            rs2_q       <= rs2_n;
            ld_q        <= ld_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            retire_q    <= retire_n;
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (rf_we && (rd_idx != '0)) begin
            rf[rd_idx] <= rf_wdata;
        end
    end

`ifdef MC_CORE_ILLEGAL_TRAP_EN
    logic halted_q;

    // Halt indicator follows the HALT state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= (state_n == S_HALT);
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign debug_pc     = pc_q;
    assign debug_instr  = ir_q;
    assign debug_retire = retire_q;

endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Multi-cycle RV32I-subset processor core; next generation of the single-cycle top.
- Replaces the fixed "pc+4 every cycle" datapath with an FSM that shares one external memory port between fetch and load/store. The port uses a req/ready handshake that allows wait states.
- Adds branches, jumps, LUI and a full ALU op decode.
- Parametrised reset vector and register count (RV32I or RV32E).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural register count; legal values 16 or 32. For 16, register index bit 4 is ignored.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  1 = write (SW), 0 = read (fetch/LW).
- mem_addr  output  32  word address; bits [1:0] always 0.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data; valid in the cycle where mem_req && mem_ready.
- mem_ready  input  1  memory accepts/completes the current transaction.
- debug_pc  output  32  PC of the instruction in flight.
- debug_instr  output  32  latched instruction register.
- debug_retire  output  1  one-cycle pulse when an instruction retires.
- halted  output  1  core in HALT state (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, IR=0.
  - All registers = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, debug_retire=0, halted=0.
- Reset mid-transaction aborts immediately. The first fetch after release is from RESET_PC.
- Handshake:
  - A transaction completes in a cycle with mem_req=1 and mem_ready=1.
  - While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata are held stable.
  - mem_req deasserts in the cycle after completion unless the next state issues a new request.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On completion, IR <= mem_rdata and go to EXEC.
  - EXEC: read rs1/rs2, compute the ALU result or target. Next state:
    - OP/OP-IMM/LUI/JAL: go to WB.
    - LW/SW: go to MEM.
    - Branch: pc <= taken ? pc+imm_b : pc+4, retire, go to FETCH.
  - MEM: mem_addr = {alu_out[31:2],2'b00}, mem_we = is_sw, mem_wdata = rs2 value. On completion:
    - LW: latch mem_rdata, go to WB.
    - SW: pc <= pc+4, retire, go to FETCH.
  - WB: write rd (LW data, ALU result, or pc+4 for JAL). Next pc = JAL ? pc+imm_j : pc+4. Retire, go to FETCH.
  - HALT: absorbing. Exited only by reset.
- Latency with zero wait states (mem_ready tied 1):
  - branch: 2 cycles.
  - ALU/LUI/JAL/SW: 3 cycles.
  - LW: 4 cycles.
  - Each wait cycle adds 1.
- Decoded instructions:
  - ADDI, SLTI, XORI, ORI, ANDI.
  - ADD, SUB (funct7[5]), SLT, XOR, OR, AND.
  - LUI, JAL, BEQ, BNE, LW, SW.
- Arithmetic:
  - 32-bit wraparound for all arithmetic; SLT/SLTI compare signed.
  - PC arithmetic wraps modulo 2^32; PC 32'hFFFF_FFFC + 4 = 0.
- Registers:
  - x0 reads 0; writes to x0 are discarded.
  - Reading and writing the same register: the read returns the old value. No write and read happen in the same state, so no bypass is needed.
- debug_retire is asserted in exactly the cycle the pc update commits.

Optional Feature:
- Macro: MC_CORE_ILLEGAL_TRAP_EN.
- Defined: any opcode/funct combination outside the decoded set, seen in EXEC, moves the core to HALT.
  - halted=1, mem_req=0, no retire pulse.
  - pc and debug_pc hold the faulting address.
- Undefined: unsupported instructions execute as NOPs.
  - pc <= pc+4, no register write, retire pulse, go to FETCH.
  - halted is tied 0.

Test Plan:
- Reset release with RESET_PC=32'h100 and mem_ready=1 → first mem_req has mem_addr=32'h100 in the first cycle after release. debug_pc=32'h100.
- ADDI x1,x0,5 then ADD x2,x1,x1 with zero-wait memory → x2=10. Two debug_retire pulses spaced 3 cycles apart.
- SW x2,8(x0) then LW x3,8(x0) against a bench memory model → write at mem_addr=8 with wdata=10; x3=10. The LW takes 4 cycles.
- Hold mem_ready=0 for 3 cycles during fetch → mem_addr and mem_req stable throughout. The instruction completes 3 cycles late.
- BNE x1,x0,-8 at pc=32'h20 with x1≠0 → next fetch address 32'h18. With x1=0 → next fetch address 32'h24.
- Illegal word 32'hFFFF_FFFF:
  - MC_CORE_ILLEGAL_TRAP_EN defined → halted=1, no further mem_req.
  - Undefined → pc advances by 4 and one retire pulse occurs.
